// File: rtl/de10_bus_pkg.sv
// Shared constants for the DE10 processor data bus: region tags, peripheral
// register word offsets and CTRL bit positions.
package de10_bus_pkg;

    localparam logic [9:0] TAG_SRAM   = 10'h0;
    localparam logic [9:0] TAG_PERIPH = 10'h1;
    localparam logic [9:0] TAG_SDRAM  = 10'h2;

    localparam int unsigned OFF_W = 6;
    localparam logic [OFF_W-1:0] OFF_LED    = 6'h00;
    localparam logic [OFF_W-1:0] OFF_SW     = 6'h01;
    localparam logic [OFF_W-1:0] OFF_CNT    = 6'h02;
    localparam logic [OFF_W-1:0] OFF_CMP    = 6'h03;
    localparam logic [OFF_W-1:0] OFF_CTRL   = 6'h04;
    localparam logic [OFF_W-1:0] OFF_STATUS = 6'h05;

    localparam int unsigned CTRL_W      = 3;
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLR    = 2;

endpackage

// File: rtl/de10_peripheral_responder_if.sv
// Peripheral-region bus between the bus controller (master) and a responder (slave).
interface de10_peripheral_responder_if;

    logic        en;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output en, ren, wen, addr, wdata, input rdata, ready);
    modport slave  (input en, ren, wen, addr, wdata, output rdata, ready);

endinterface

// File: rtl/de10_timer.sv
// Prescaled 32-bit timer: CNT/CMP/CTRL registers and a sticky compare-match flag.
module de10_timer
    import de10_bus_pkg::*;
#(
    parameter int unsigned PRESCALE = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cnt_we,
    input  logic              i_cmp_we,
    input  logic              i_ctrl_we,
    input  logic              i_status_w1c,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_cnt,
    output logic [31:0]       o_cmp,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_match
);

    localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]     r_pre;
    logic [31:0]       r_cnt;
    logic [31:0]       r_cmp;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_match;
    logic              w_tick;
    logic              w_hit;

    assign w_tick = r_ctrl[CTRL_EN] && (r_pre == PRE_LAST);
    assign w_hit  = w_tick && (r_cnt == r_cmp);

    // Prescaler parks at zero whenever the timer is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_pre <= '0;
        else if (!r_ctrl[CTRL_EN] || w_tick)       r_pre <= '0;
        else                                       r_pre <= r_pre + PW'(1);
    end

    // A software write to CNT overrides the tick update in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_cnt <= '0;
        else if (i_cnt_we)                         r_cnt <= i_wdata;
        else if (w_hit && r_ctrl[CTRL_CLR])        r_cnt <= '0;
        else if (w_tick)                           r_cnt <= r_cnt + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp  <= '1;
            r_ctrl <= '0;
        end else begin
            if (i_cmp_we)  r_cmp  <= i_wdata;
            if (i_ctrl_we) r_ctrl <= i_wdata[CTRL_W-1:0];
        end
    end

    // A new match takes priority over a simultaneous write-one-to-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_match <= 1'b0;
        else if (w_hit)        r_match <= 1'b1;
        else if (i_status_w1c) r_match <= 1'b0;
    end

    assign o_cnt   = r_cnt;
    assign o_cmp   = r_cmp;
    assign o_ctrl  = r_ctrl;
    assign o_match = r_match;

endmodule

// File: rtl/de10_peripheral_responder.sv
// Peripheral-region responder: register decode, read mux, LED/switch registers,
// single-cycle ready generation and the timer interrupt.
module de10_peripheral_responder
    import de10_bus_pkg::*;
#(
    parameter int unsigned N_LED    = 10,
    parameter int unsigned N_SW     = 10,
    parameter int unsigned PRESCALE = 50
) (
    input  logic                      clk,
    input  logic                      rst,
    de10_peripheral_responder_if.slave bus,
    output logic [N_LED-1:0]          leds,
    input  logic [N_SW-1:0]           sw,
    output logic                      irq
);

    logic              w_acc;
    logic              w_wr;
    logic              w_rd;
    logic [OFF_W-1:0]  w_off;
    logic [31:0]       w_rmux;
    logic [31:0]       w_cnt;
    logic [31:0]       w_cmp;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_match;
    logic              w_unused;

    logic [31:0]       r_rdata;
    logic              r_ready;
    logic [N_LED-1:0]  r_leds;
    logic [N_SW-1:0]   r_sw_s1;
    logic [N_SW-1:0]   r_sw_s2;

    // A combined read+write strobe is treated as a pure write
    assign w_acc    = bus.en & (bus.ren | bus.wen);
    assign w_wr     = bus.en & bus.wen;
    assign w_rd     = bus.en & bus.ren & ~bus.wen;
    assign w_off    = bus.addr[7:2];
    assign w_unused = ^{bus.addr[31:8], bus.addr[1:0]};

    de10_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_cnt_we     (w_wr && (w_off == OFF_CNT)),
        .i_cmp_we     (w_wr && (w_off == OFF_CMP)),
        .i_ctrl_we    (w_wr && (w_off == OFF_CTRL)),
        .i_status_w1c (w_wr && (w_off == OFF_STATUS) && bus.wdata[0]),
        .i_wdata      (bus.wdata),
        .o_cnt        (w_cnt),
        .o_cmp        (w_cmp),
        .o_ctrl       (w_ctrl),
        .o_match      (w_match)
    );

    always_comb begin
        w_rmux = '0;
        case (w_off)
            OFF_LED:    w_rmux = 32'(r_leds);
            OFF_SW:     w_rmux = 32'(r_sw_s2);
            OFF_CNT:    w_rmux = w_cnt;
            OFF_CMP:    w_rmux = w_cmp;
            OFF_CTRL:   w_rmux = 32'(w_ctrl);
            OFF_STATUS: w_rmux = 32'(w_match);
            default:    w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_leds  <= '0;
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_ready <= w_acc;
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
            if (w_rd)                         r_rdata <= w_rmux;
            if (w_wr && (w_off == OFF_LED))   r_leds  <= bus.wdata[N_LED-1:0];
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign leds      = r_leds;
    assign irq       = w_match & w_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_de10_peripheral_responder.sv
// Directed bench for de10_peripheral_responder: two instances (PRESCALE 4 and 1)
// sharing one bus driver, selected by r_sel.
module tb_de10_peripheral_responder;
    import de10_bus_pkg::*;

    logic        clk;
    logic        rst;
    logic        r_sel;
    logic        r_en;
    logic        r_ren;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [9:0]  r_sw;
    logic [9:0]  w_leds0;
    logic [9:0]  w_leds1;
    logic        w_irq0;
    logic        w_irq1;
    logic [31:0] w_rdata;
    logic        w_ready;
    logic [9:0]  w_leds;
    logic        w_irq;

    int n_chk  = 0;
    int n_fail = 0;

    de10_peripheral_responder_if bus0 ();
    de10_peripheral_responder_if bus1 ();

    assign bus0.en    = r_en & ~r_sel;
    assign bus1.en    = r_en & r_sel;
    assign bus0.ren   = r_ren;
    assign bus1.ren   = r_ren;
    assign bus0.wen   = r_wen;
    assign bus1.wen   = r_wen;
    assign bus0.addr  = r_addr;
    assign bus1.addr  = r_addr;
    assign bus0.wdata = r_wdata;
    assign bus1.wdata = r_wdata;

    assign w_rdata = r_sel ? bus1.rdata : bus0.rdata;
    assign w_ready = r_sel ? bus1.ready : bus0.ready;
    assign w_leds  = r_sel ? w_leds1 : w_leds0;
    assign w_irq   = r_sel ? w_irq1 : w_irq0;

    de10_peripheral_responder #(.N_LED(10), .N_SW(10), .PRESCALE(4)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus0.slave),
        .leds (w_leds0),
        .sw   (r_sw),
        .irq  (w_irq0)
    );

    de10_peripheral_responder #(.N_LED(10), .N_SW(10), .PRESCALE(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1.slave),
        .leds (w_leds1),
        .sw   (r_sw),
        .irq  (w_irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [5:0] off);
        return {TAG_PERIPH, 14'h0, off, 2'b00};
    endfunction

    // Called at a negedge; accepts at the next posedge, returns at the following negedge
    task automatic rd(input logic [5:0] off, input logic [31:0] exp, input string tag);
        r_addr = reg_addr(off);
        r_en   = 1'b1;
        r_ren  = 1'b1;
        r_wen  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        r_en  = 1'b0;
        r_ren = 1'b0;
        chk({tag, "_rdy"}, 32'(w_ready), 32'd1);
        chk(tag, w_rdata, exp);
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] data, input string tag);
        r_addr  = reg_addr(off);
        r_wdata = data;
        r_en    = 1'b1;
        r_ren   = 1'b0;
        r_wen   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_en  = 1'b0;
        r_wen = 1'b0;
        chk({tag, "_rdy"}, 32'(w_ready), 32'd1);
    endtask

    logic [31:0] reset_vals [6];

    initial begin
        reset_vals = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        rst     = 1'b1;
        r_sel   = 1'b0;
        r_en    = 1'b0;
        r_ren   = 1'b0;
        r_wen   = 1'b0;
        r_addr  = '0;
        r_wdata = '0;
        r_sw    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(w_ready), 32'd0);
        chk("rst_rdata", w_rdata, 32'd0);
        chk("rst_leds", 32'(w_leds), 32'd0);
        chk("rst_irq", 32'(w_irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset values of every register, ready exactly one cycle wide
        for (int i = 0; i < 6; i++) begin
            rd(6'(i), reset_vals[i], "t1_rd");
            @(negedge clk);
            chk("t1_rdy_drop", 32'(w_ready), 32'd0);
        end

        // 2: LED register, width truncation, strobes without en
        wr(OFF_LED, 32'h0000_03FF, "t2_wr_led");
        chk("t2_leds", 32'(w_leds), 32'h3FF);
        rd(OFF_LED, 32'h3FF, "t2_rd_led");
        wr(OFF_LED, 32'hFFFF_FFFF, "t2_wr_led_ff");
        rd(OFF_LED, 32'h3FF, "t2_rd_led_ff");
        r_addr  = reg_addr(OFF_LED);
        r_wdata = 32'h0;
        r_wen   = 1'b1;
        r_ren   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_wen = 1'b0;
        r_ren = 1'b0;
        chk("t2_noen_ready", 32'(w_ready), 32'd0);
        chk("t2_noen_leds", 32'(w_leds), 32'h3FF);

        // 3: switch synchroniser latency, SW writes ignored, unmapped offset
        r_sw = 10'h155;
        rd(OFF_SW, 32'h0, "t3_sw_early");
        wr(OFF_SW, 32'hFFFF_FFFF, "t3_wr_sw");
        rd(OFF_SW, 32'h155, "t3_sw_sync");
        rd(6'h07, 32'h0, "t3_unmapped");

        // 4: PRESCALE=4, CMP=3, clear-on-match with interrupt
        wr(OFF_CMP, 32'd3, "t4_wr_cmp");
        wr(OFF_CTRL, 32'h7, "t4_wr_ctrl");
        repeat (15) @(negedge clk);
        chk("t4_irq_cycle15", 32'(w_irq), 32'd0);
        @(negedge clk);
        chk("t4_irq_cycle16", 32'(w_irq), 32'd1);
        rd(OFF_STATUS, 32'd1, "t4_status");
        rd(OFF_CNT, 32'd0, "t4_cnt_cleared");
        wr(OFF_STATUS, 32'd1, "t4_w1c");
        chk("t4_irq_drop", 32'(w_irq), 32'd0);
        wr(OFF_CTRL, 32'h0, "t4_disable");

        // 5: PRESCALE=1 instance: wrap, write-vs-tick, match-vs-W1C
        r_sel = 1'b1;
        wr(OFF_CNT, 32'hFFFF_FFFF, "t5_wr_cnt");
        wr(OFF_CMP, 32'd5, "t5_wr_cmp");
        wr(OFF_CTRL, 32'h1, "t5_wr_ctrl");
        rd(OFF_CNT, 32'hFFFF_FFFF, "t5_cnt_max");
        rd(OFF_CNT, 32'h0, "t5_cnt_wrap");
        rd(OFF_STATUS, 32'h0, "t5_no_match");
        wr(OFF_CNT, 32'h100, "t5_wr_cnt_tick");
        rd(OFF_CNT, 32'h100, "t5_cnt_write_wins");
        rd(OFF_CNT, 32'h101, "t5_cnt_resumes");
        wr(OFF_CNT, 32'd3, "t5_wr_cnt3");
        repeat (2) @(negedge clk);
        wr(OFF_STATUS, 32'd1, "t5_w1c_on_match");
        rd(OFF_STATUS, 32'd1, "t5_set_wins");
        wr(OFF_STATUS, 32'd1, "t5_w1c_plain");
        rd(OFF_STATUS, 32'd0, "t5_cleared");
        wr(OFF_CTRL, 32'h0, "t5_disable");
        r_sel = 1'b0;

        // 6: simultaneous read+write, then reset right after an access
        rd(OFF_LED, 32'h3FF, "t6_prime_rdata");
        r_addr  = reg_addr(OFF_CMP);
        r_wdata = 32'h10;
        r_en    = 1'b1;
        r_ren   = 1'b1;
        r_wen   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_en  = 1'b0;
        r_ren = 1'b0;
        r_wen = 1'b0;
        chk("t6_rw_ready", 32'(w_ready), 32'd1);
        chk("t6_rw_rdata", w_rdata, 32'h3FF);
        @(negedge clk);
        chk("t6_rw_single", 32'(w_ready), 32'd0);
        rd(OFF_CMP, 32'h10, "t6_cmp");
        wr(OFF_CNT, 32'h55, "t6_wr_cnt");
        wr(OFF_CTRL, 32'h6, "t6_wr_ctrl");
        wr(OFF_LED, 32'h2A, "t6_wr_led");
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 32'(w_ready), 32'd0);
        chk("t6_rst_rdata", w_rdata, 32'd0);
        chk("t6_rst_leds", 32'(w_leds), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        r_sw = 10'h0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rd(6'(i), reset_vals[i], "t6_post_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
